cmd_frame_parser: RTL
=====================

# cmd_frame_parser

Downstream stage of the UART input block in the vector accelerator. It consumes the received byte stream through a valid/ready handshake and frames it as `SYNC, OP, LEN, DATA[LEN], CSUM`. Operand bytes are written into the vector operand buffer as they arrive. When the checksum matches, the block issues one command (opcode plus length) to the execution controller. On malformed framing, bad checksum or an inter-byte gap it reports an error and resynchronises.

## Interface
- `MAX_LEN`, 16: maximum operand bytes per frame; legal LEN range is 1..MAX_LEN.
- `TIMEOUT_CYCLES`, 10_000: maximum idle clocks between accepted bytes inside a frame.
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports:
- Clocking/reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  8  received byte from the input block.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  parser accepts a byte this cycle.
- `vec_we`  out  1  operand buffer write strobe.
- `vec_addr`  out  $clog2(MAX_LEN)  operand index, 0-based.
- `vec_wdata`  out  8  operand byte.
- `cmd_valid`  out  1  command available.
- `cmd_ready`  in  1  controller takes the command.
- `cmd_op`  out  8  opcode.
- `cmd_len`  out  $clog2(MAX_LEN)+1  operand count.
- `err`  out  1  one-cycle error pulse.
- `err_code`  out  2  error cause: 01 = bad LEN, 10 = checksum mismatch, 11 = timeout; held until the next error.

## Operation
- A byte is accepted on any rising edge where `in_valid && in_ready` is true.
- FSM states: IDLE, OP, LEN, DATA, CSUM, ISSUE.
  - IDLE: discard bytes other than SYNC_BYTE. On SYNC_BYTE, go to OP.
  - OP: latch `cmd_op`; running checksum = byte; go to LEN.
  - LEN: if LEN is 0 or greater than MAX_LEN, raise error 01 and go to IDLE. Otherwise latch `cmd_len`, XOR the byte into the checksum, clear the index, and go to DATA.
  - DATA: write each byte at the current index, XOR it into the checksum, and increment the index. After LEN bytes, go to CSUM.
  - CSUM: if the byte equals the running XOR, go to ISSUE. Otherwise raise error 10 and go to IDLE.
  - ISSUE: `cmd_valid` = 1 and `in_ready` = 0. When `cmd_ready` is seen, go to IDLE.
- `in_ready` = 1 in every state except ISSUE.
- Checksum covers OP, LEN and DATA only; SYNC is excluded. All arithmetic is 8-bit XOR.
- Buffer contents after a failed frame are undefined. The controller only trusts the buffer after `cmd_valid`.
- Gap timer:
  - Runs in OP, LEN, DATA and CSUM.
  - Cleared on each accepted byte and on entry to IDLE.
  - On reaching TIMEOUT_CYCLES, raise error 11 and go to IDLE.
  - If a byte is accepted in the same cycle the timer would expire, the byte wins.

## Timing
- Reset values: `in_ready` = 1 (IDLE); `vec_we`, `cmd_valid`, `err` = 0; `vec_addr`, `vec_wdata`, `cmd_op`, `cmd_len`, `err_code` = 0; FSM = IDLE.
- Reset mid-frame aborts the frame without raising `err`.
- All outputs are registered.
- `vec_we` is high for exactly one cycle, the cycle after a DATA byte is accepted, with the matching `vec_addr`/`vec_wdata`.
- `cmd_valid` rises the cycle after the CSUM byte is accepted. It stays high, with `cmd_op`/`cmd_len` stable, until the cycle `cmd_ready` = 1. It drops the following cycle, and `in_ready` returns to 1 in that same cycle.
- `err` rises the cycle after the offending byte or the timeout. `err_code` updates in the same cycle.
- Back-to-back bytes are sustained at one per cycle in every state except ISSUE.

## Structure
- Package `cmd_pkg` holds:
  - the `parse_state_t` enum;
  - the `err_code_t` enum (ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT);
  - the SYNC_BYTE default;
  - shared by the execution controller.
- Sub-module `gap_timer`:
  - inputs `clk`, `rst`, `clear`, `enable`;
  - output `expired`;
  - parameter TIMEOUT_CYCLES.

## Test plan
- Good frame: send A5 01 02 10 20 33 with `cmd_ready` = 1 → writes (0,10h) then (1,20h); `cmd_valid` for one cycle with op 01h, len 2; no `err`.
- Bad checksum: send A5 01 02 10 20 34 → two buffer writes, no `cmd_valid`, `err` pulse with code 10; a following good frame is then accepted.
- Bad length: send A5 07 00, then A5 07 11h → each gives an `err` pulse with code 01; the parser returns to IDLE after each.
- Garbage and resync: send 00 FF A5 A5 … → the leading bytes are ignored; the second A5 is taken as OP (A5h).
- Timeout: send A5 01, then idle for TIMEOUT_CYCLES → `err` pulse with code 11. Repeat with a byte arriving exactly on the expiry cycle → no error.
- Backpressure and reset: hold `cmd_ready` = 0 for 50 cycles → `cmd_valid` and `cmd_op` stay stable and `in_ready` = 0. Assert `rst` mid-DATA → all outputs return to reset values and no `err` is raised.

Source files
------------

// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - shared command-frame types and constants
package cmd_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OP,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_ISSUE
    } parse_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_LEN     = 2'b01,
        ERR_CSUM    = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_code_t;

endpackage

// File: rtl/gap_timer.sv
// rtl/gap_timer.sv - inter-byte idle timer
module gap_timer #(
    parameter int TIMEOUT_CYCLES = 10_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // Asserted on the edge that would bring the idle count to TIMEOUT_CYCLES;
    // the owner gives a simultaneous byte priority over this.
    assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cmd_frame_parser.sv
// rtl/cmd_frame_parser.sv - SYNC/OP/LEN/DATA/CSUM frame parser with command issue
module cmd_frame_parser
    import cmd_pkg::*;
#(
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 10_000,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         vec_we,
    output logic [$clog2(MAX_LEN)-1:0]   vec_addr,
    output logic [7:0]                   vec_wdata,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic [7:0]                   cmd_op,
    output logic [$clog2(MAX_LEN):0]     cmd_len,
    output logic                         err,
    output logic [1:0]                   err_code
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = AW + 1;

    parse_state_t  state, state_next;
    logic [LW-1:0] cnt;
    logic [7:0]    csum;
    logic          accept;
    logic          len_bad;
    logic          data_last;
    logic          tmr_enable;
    logic          tmr_expired;
    logic          err_set;
    err_code_t     err_next;

    assign accept     = in_valid && in_ready;
    assign len_bad    = (in_data == 8'd0) || (in_data > 8'(MAX_LEN));
    assign data_last  = (cnt + LW'(1)) == cmd_len;
    assign tmr_enable = state inside {ST_OP, ST_LEN, ST_DATA, ST_CSUM};

    gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        err_set    = 1'b0;
        err_next   = ERR_NONE;
        case (state)
            ST_IDLE: begin
                if (accept && (in_data == SYNC_BYTE)) begin
                    state_next = ST_OP;
                end
            end
            ST_OP: begin
                if (accept) begin
                    state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    if (len_bad) begin
                        state_next = ST_IDLE;
                        err_set    = 1'b1;
                        err_next   = ERR_LEN;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept && data_last) begin
                    state_next = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (in_data == csum) begin
                        state_next = ST_ISSUE;
                    end else begin
                        state_next = ST_IDLE;
                        err_set    = 1'b1;
                        err_next   = ERR_CSUM;
                    end
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // A byte landing on the expiry edge keeps the frame alive.
        if (tmr_expired && !accept) begin
            state_next = ST_IDLE;
            err_set    = 1'b1;
            err_next   = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            cmd_valid <= 1'b0;
            vec_we    <= 1'b0;
            vec_addr  <= '0;
            vec_wdata <= '0;
            cmd_op    <= '0;
            cmd_len   <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            csum      <= '0;
            cnt       <= '0;
        end else begin
            // Handshake outputs are registered from the next state so they
            // line up with the state they describe.
            in_ready  <= (state_next != ST_ISSUE);
            cmd_valid <= (state_next == ST_ISSUE);
            vec_we    <= (state == ST_DATA) && accept;
            err       <= err_set;
            if (err_set) begin
                err_code <= err_next;
            end
            if (accept) begin
                case (state)
                    ST_OP: begin
                        cmd_op <= in_data;
                        csum   <= in_data;
                    end
                    ST_LEN: begin
                        if (!len_bad) begin
                            cmd_len <= in_data[LW-1:0];
                            csum    <= csum ^ in_data;
                            cnt     <= '0;
                        end
                    end
                    ST_DATA: begin
                        vec_addr  <= cnt[AW-1:0];
                        vec_wdata <= in_data;
                        csum      <= csum ^ in_data;
                        cnt       <= cnt + LW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
